// File: rtl/apb_2_lint.sv
// APB slave to LINT master bridge: one outstanding transfer, registered APB completion,
// optional timeout that completes the APB access with PSLVERR when the LINT side stalls.
module apb_2_lint #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255,
  localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  PWRITE,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic                  data_req_o,
  output logic [ADDR_WIDTH-1:0] data_add_o,
  output logic                  data_we_o,
  output logic [DATA_WIDTH-1:0] data_wdata_o,
  output logic [BE_WIDTH-1:0]   data_be_o,
  input  logic                  data_gnt_i,
  input  logic                  data_r_valid_i,
  input  logic [DATA_WIDTH-1:0] data_r_rdata_i
);

  localparam int unsigned CntWidth = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntWidth-1:0] TimeoutVal = CntWidth'(TIMEOUT);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StWait = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d, cnt_inc;
  logic                  timeout_hit;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;

  always_comb begin
    cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    // cnt_inc is the number of REQ/WAIT cycles including the current one
    timeout_hit = (TIMEOUT != 0) && (cnt_inc == TimeoutVal);

    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    prdata_d  = prdata_q;
    pready_d  = 1'b0;
    pslverr_d = pslverr_q;

    case (state_q)
      StIdle: begin
        if (PSEL && !PENABLE) begin
          addr_d  = PADDR;
          wdata_d = PWDATA;
          we_d    = PWRITE;
          cnt_d   = '0;
          state_d = StReq;
        end
      end
      StReq: begin
        cnt_d = cnt_inc;
        if (timeout_hit) begin
          state_d   = StDone;
          prdata_d  = '0;
          pslverr_d = 1'b1;
          pready_d  = 1'b1;
        end else if (data_gnt_i) begin
          state_d = StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_inc;
        // A response on the final allowed cycle still completes normally
        if (data_r_valid_i) begin
          state_d   = StDone;
          prdata_d  = we_q ? '0 : data_r_rdata_i;
          pslverr_d = 1'b0;
          pready_d  = 1'b1;
        end else if (timeout_hit) begin
          state_d   = StDone;
          prdata_d  = '0;
          pslverr_d = 1'b1;
          pready_d  = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
    end
  end

  assign data_req_o   = (state_q == StReq);
  assign data_be_o    = {BE_WIDTH{data_req_o}};
  assign data_add_o   = addr_q;
  assign data_we_o    = we_q;
  assign data_wdata_o = wdata_q;
  assign PRDATA       = prdata_q;
  assign PREADY       = pready_q;
  assign PSLVERR      = pslverr_q;

endmodule

// File: tb/tb_apb_2_lint.sv
// Directed bench for apb_2_lint: a transaction-level schedule model sets the expected outputs
// for every cycle, and a negedge process compares all DUT outputs against it.
module tb_apb_2_lint;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic          PWRITE, PSEL, PENABLE;
  logic [DW-1:0] PRDATA;
  logic          PREADY, PSLVERR;
  logic          data_req_o, data_we_o;
  logic [AW-1:0] data_add_o;
  logic [DW-1:0] data_wdata_o;
  logic [BW-1:0] data_be_o;
  logic          data_gnt_i, data_r_valid_i;
  logic [DW-1:0] data_r_rdata_i;

  apb_2_lint #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT   (TO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .PADDR         (PADDR),
    .PWDATA        (PWDATA),
    .PWRITE        (PWRITE),
    .PSEL          (PSEL),
    .PENABLE       (PENABLE),
    .PRDATA        (PRDATA),
    .PREADY        (PREADY),
    .PSLVERR       (PSLVERR),
    .data_req_o    (data_req_o),
    .data_add_o    (data_add_o),
    .data_we_o     (data_we_o),
    .data_wdata_o  (data_wdata_o),
    .data_be_o     (data_be_o),
    .data_gnt_i    (data_gnt_i),
    .data_r_valid_i(data_r_valid_i),
    .data_r_rdata_i(data_r_rdata_i)
  );

  always #5 clk = ~clk;

  // Expected outputs for the current cycle
  logic          exp_req, exp_we, exp_ready, exp_slverr;
  logic [AW-1:0] exp_add;
  logic [DW-1:0] exp_wdata, exp_prdata;
  logic [BW-1:0] exp_be;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;
  int req_seen = 0;
  int ready_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("data_req_o", data_req_o, exp_req);
      check("data_add_o", data_add_o, exp_add);
      check("data_we_o", data_we_o, exp_we);
      check("data_wdata_o", data_wdata_o, exp_wdata);
      check("data_be_o", data_be_o, exp_be);
      check("PREADY", PREADY, exp_ready);
      check("PRDATA", PRDATA, exp_prdata);
      check("PSLVERR", PSLVERR, exp_slverr);
      if (data_req_o === 1'b1) req_seen++;
      if (PREADY === 1'b1) ready_seen++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_reset_expect();
    exp_req = 0; exp_we = 0; exp_ready = 0; exp_slverr = 0;
    exp_add = '0; exp_wdata = '0; exp_prdata = '0; exp_be = '0;
  endtask

  task automatic idle_cycles(input int n, input bit stray);
    for (int i = 0; i < n; i++) begin
      step();
      PSEL = 0; PENABLE = 0;
      data_gnt_i = stray; data_r_valid_i = stray; data_r_rdata_i = 32'hFACE_0FF0;
      exp_req = 0; exp_be = '0; exp_ready = 0;
    end
  endtask

  // One APB transfer; gnt after gnt_dly stall cycles (never if !grant), rvalid rv_dly cycles
  // after grant. Returns with the DONE cycle as the current cycle.
  task automatic xfer(input logic [AW-1:0] addr, input logic [DW-1:0] wdata, input logic we,
                      input bit grant, input int gnt_dly, input int rv_dly,
                      input logic [DW-1:0] rdata, input bit stray_rv, input bit drop_psel);
    int req_cyc, wait_cyc;
    bit to, gnt_in_req;
    if (!grant || gnt_dly + 1 >= TO) begin
      to = 1; req_cyc = TO; wait_cyc = 0; gnt_in_req = 0;
    end else if (gnt_dly + 1 + rv_dly > TO) begin
      to = 1; req_cyc = gnt_dly + 1; wait_cyc = TO - req_cyc; gnt_in_req = 1;
    end else begin
      to = 0; req_cyc = gnt_dly + 1; wait_cyc = rv_dly; gnt_in_req = 1;
    end
    step();
    PSEL = 1; PENABLE = 0; PADDR = addr; PWDATA = wdata; PWRITE = we;
    data_gnt_i = 0; data_r_valid_i = 0;
    exp_req = 0; exp_be = '0; exp_ready = 0;
    for (int i = 0; i < req_cyc; i++) begin
      step();
      PSEL = !drop_psel; PENABLE = !drop_psel;
      PADDR = ~addr; PWDATA = ~wdata; PWRITE = ~we;
      exp_add = addr; exp_wdata = wdata; exp_we = we;
      exp_req = 1; exp_be = '1; exp_ready = 0;
      data_gnt_i = gnt_in_req && (i == req_cyc - 1);
      data_r_valid_i = stray_rv && data_gnt_i;
      data_r_rdata_i = 32'hBAD0_0000;
    end
    for (int j = 0; j < wait_cyc; j++) begin
      step();
      exp_req = 0; exp_be = '0;
      data_gnt_i = 0;
      data_r_valid_i = !to && (j == wait_cyc - 1);
      data_r_rdata_i = data_r_valid_i ? rdata : 32'h5555_AAAA;
    end
    step();
    data_gnt_i = 0; data_r_valid_i = 0;
    exp_req = 0; exp_be = '0; exp_ready = 1;
    exp_slverr = to;
    exp_prdata = (to || we) ? '0 : rdata;
  endtask

  int r0, p0;

  initial begin
    rst_n = 0; PADDR = '0; PWDATA = '0; PWRITE = 0; PSEL = 0; PENABLE = 0;
    data_gnt_i = 0; data_r_valid_i = 0; data_r_rdata_i = '0;
    step();
    set_reset_expect();
    chk_en = 1'b1;
    step();
    rst_n = 1;
    idle_cycles(2, 1'b0);

    // Minimal read
    xfer(32'h1A10_0004, 32'h0, 1'b0, 1'b1, 0, 1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    check("read_prdata_lit", PRDATA, 32'hDEAD_BEEF);
    check("read_slverr_lit", PSLVERR, 1'b0);
    idle_cycles(2, 1'b0);

    // Write with grant stalls
    r0 = req_seen; p0 = ready_seen;
    xfer(32'h0000_0100, 32'h1234_5678, 1'b1, 1'b1, 3, 2, 32'hCAFE_F00D, 1'b0, 1'b0);
    idle_cycles(1, 1'b0);
    check("write_req_cycles", req_seen - r0, 4);
    check("write_ready_pulses", ready_seen - p0, 1);
    check("write_prdata_lit", PRDATA, 32'h0);

    // Timeout with no grant, then stray gnt/rvalid
    p0 = ready_seen;
    xfer(32'h2000_0008, 32'h0, 1'b0, 1'b0, 0, 0, 32'h0, 1'b0, 1'b0);
    check("timeout_slverr_lit", PSLVERR, 1'b1);
    check("timeout_prdata_lit", PRDATA, 32'h0);
    idle_cycles(4, 1'b1);
    check("timeout_ready_pulses", ready_seen - p0, 1);

    // Back-to-back write then read
    r0 = req_seen; p0 = ready_seen;
    xfer(32'h3000_0000, 32'hA5A5_5A5A, 1'b1, 1'b1, 0, 1, 32'h0, 1'b0, 1'b0);
    xfer(32'h3000_0004, 32'h0, 1'b0, 1'b1, 0, 1, 32'h0BAD_CAFE, 1'b0, 1'b0);
    idle_cycles(1, 1'b0);
    check("b2b_req_cycles", req_seen - r0, 2);
    check("b2b_ready_pulses", ready_seen - p0, 2);

    // rvalid with grant ignored; PSEL dropped mid-transfer; timeout while waiting
    xfer(32'h4000_0010, 32'h0, 1'b0, 1'b1, 1, 3, 32'h7777_1234, 1'b1, 1'b0);
    xfer(32'h4000_0014, 32'h0, 1'b0, 1'b1, 0, 2, 32'h0123_4567, 1'b0, 1'b1);
    idle_cycles(1, 1'b0);
    xfer(32'h4000_0018, 32'h0, 1'b0, 1'b1, 2, 10, 32'h0, 1'b0, 1'b0);
    idle_cycles(2, 1'b0);

    // Reset while in WAIT, then late response
    p0 = ready_seen;
    step();
    PSEL = 1; PENABLE = 0; PADDR = 32'h5000_0040; PWDATA = 32'h1111_2222; PWRITE = 1;
    step();
    PENABLE = 1; data_gnt_i = 1;
    exp_add = 32'h5000_0040; exp_wdata = 32'h1111_2222; exp_we = 1; exp_req = 1; exp_be = '1;
    step();
    data_gnt_i = 0; PSEL = 0; PENABLE = 0; rst_n = 0;
    exp_req = 0; exp_be = '0;
    step();
    rst_n = 1; data_r_valid_i = 1; data_r_rdata_i = 32'hFFFF_FFFF;
    set_reset_expect();
    idle_cycles(3, 1'b0);
    check("reset_wait_no_ready", ready_seen - p0, 0);
    xfer(32'h6000_0000, 32'h0, 1'b0, 1'b1, 0, 1, 32'h600D_D00D, 1'b0, 1'b0);
    check("post_reset_prdata_lit", PRDATA, 32'h600D_D00D);
    idle_cycles(2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
